// File: rtl/gmux_quad_clk_ctrl.sv
// Per-quadrant sequencer for GMUX SEN/DEN/DYNEN/VLP controls and the SSEL source select.
// Each quadrant runs its own SLEEP->WAKE->ENABLE->ACTIVE->QUIESCE sequence with a private timer.
module gmux_quad_clk_ctrl #(
  parameter int unsigned NUM_QUAD   = 4,
  parameter int unsigned WAKE_CYC   = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      =
    $clog2(((WAKE_CYC > SETTLE_CYC) ? WAKE_CYC : SETTLE_CYC) + 1)
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic [NUM_QUAD-1:0] ON_REQ,
  input  logic [NUM_QUAD-1:0] DYN_MODE,
  output logic [NUM_QUAD-1:0] SEN,
  output logic [NUM_QUAD-1:0] DEN,
  output logic [NUM_QUAD-1:0] DYNEN,
  output logic [NUM_QUAD-1:0] VLP,
  output logic [NUM_QUAD-1:0] RDY,
  output logic                SSEL,
  output logic                BUSY
);

  typedef enum logic [2:0] {
    SLEEP,
    WAKE,
    ENABLE,
    ACTIVE,
    QUIESCE
  } state_t;

  localparam logic [CNT_W-1:0] WAKE_LD   = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t             state_q [NUM_QUAD];
  state_t             state_d [NUM_QUAD];
  logic [CNT_W-1:0]   tmr_q   [NUM_QUAD];
  logic [CNT_W-1:0]   tmr_d   [NUM_QUAD];
  logic [NUM_QUAD-1:0] mode_q;
  logic [NUM_QUAD-1:0] mode_d;
  logic [NUM_QUAD-1:0] busy_vec;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int unsigned i = 0; i < NUM_QUAD; i++) begin
        state_q[i] <= SLEEP;
        tmr_q[i]   <= '0;
      end
      mode_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_QUAD; i++) begin
        state_q[i] <= state_d[i];
        tmr_q[i]   <= tmr_d[i];
      end
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    for (int unsigned i = 0; i < NUM_QUAD; i++) begin
      state_d[i] = state_q[i];
      tmr_d[i]   = tmr_q[i];
      case (state_q[i])
        SLEEP: begin
          if (ON_REQ[i]) begin
            mode_d[i]  = DYN_MODE[i];
            tmr_d[i]   = WAKE_LD;
            state_d[i] = WAKE;
          end
        end
        WAKE: begin
          // Abort wins over timer expiry: no enable has been driven yet.
          if (!ON_REQ[i]) begin
            state_d[i] = SLEEP;
          end else if (tmr_q[i] == '0) begin
            tmr_d[i]   = SETTLE_LD;
            state_d[i] = ENABLE;
          end else begin
            tmr_d[i] = tmr_q[i] - ONE;
          end
        end
        ENABLE: begin
          if (tmr_q[i] == '0) state_d[i] = ACTIVE;
          else                tmr_d[i]   = tmr_q[i] - ONE;
        end
        ACTIVE: begin
          if (!ON_REQ[i]) begin
            tmr_d[i]   = SETTLE_LD;
            state_d[i] = QUIESCE;
          end
        end
        QUIESCE: begin
          if (tmr_q[i] == '0) state_d[i] = SLEEP;
          else                tmr_d[i]   = tmr_q[i] - ONE;
        end
        default: state_d[i] = SLEEP;
      endcase
    end
  end

  always_comb begin
    SEN      = '0;
    DEN      = '0;
    DYNEN    = '0;
    VLP      = '1;
    RDY      = '0;
    busy_vec = '0;
    for (int unsigned i = 0; i < NUM_QUAD; i++) begin
      case (state_q[i])
        WAKE: begin
          VLP[i]      = 1'b0;
          busy_vec[i] = 1'b1;
        end
        ENABLE, ACTIVE: begin
          VLP[i]   = 1'b0;
          SEN[i]   = ~mode_q[i];
          DEN[i]   = mode_q[i];
          DYNEN[i] = mode_q[i];
          if (state_q[i] == ACTIVE) RDY[i]      = 1'b1;
          else                      busy_vec[i] = 1'b1;
        end
        QUIESCE: begin
          VLP[i]      = 1'b0;
          DYNEN[i]    = mode_q[i];
          busy_vec[i] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign SSEL = |RDY;
  assign BUSY = |busy_vec;

endmodule

// File: doc/gmux_quad_clk_ctrl.md
Name: gmux_quad_clk_ctrl

Overview:
- Sequencer for the per-quadrant controls of a global high-speed clock mux: SEN, DEN, DYNEN and VLP, plus mux select SSEL.
- Generalises the fixed four-quadrant static-enable configuration to NUM_QUAD quadrants.
- Each quadrant has its own request/ready handshake, timed wake-up and quiesce sequences, and a static or dynamic enable mode chosen per request.
- Sits between the fabric power/clock manager and the GMUX control pins; GMUX timing arcs stay valid only while a quadrant is ACTIVE.

Parameters:
- NUM_QUAD, 4, number of clock quadrants controlled (>=1).
- WAKE_CYC, 4, cycles VLP is held low before any enable is asserted (>=1).
- SETTLE_CYC, 2, cycles an enable is held before RDY, and enable-off time before VLP is reasserted (>=1).
- CNT_W, clog2(max(WAKE_CYC,SETTLE_CYC)+1), width of the per-quadrant timer.

Ports:
- CLK  input  1  controller clock; all state changes on the rising edge.
- RSTN  input  1  asynchronous active-low reset.
- ON_REQ  input  NUM_QUAD  level request; 1 = quadrant clock wanted.
- DYN_MODE  input  NUM_QUAD  mode, sampled when leaving SLEEP; 1 = dynamic enable, 0 = static.
- SEN  output  NUM_QUAD  static enable per quadrant.
- DEN  output  NUM_QUAD  dynamic enable per quadrant.
- DYNEN  output  NUM_QUAD  dynamic-mode flag per quadrant.
- VLP  output  NUM_QUAD  very-low-power per quadrant; 1 = powered down.
- RDY  output  NUM_QUAD  1 = quadrant ACTIVE, clock valid.
- SSEL  output  1  high-speed source select; 1 while any quadrant is ACTIVE.
- BUSY  output  1  1 while any quadrant is in WAKE, ENABLE or QUIESCE.

Behaviour:
- Reset (RSTN=0, asynchronous): every quadrant in SLEEP, timers 0, mode latch 0.
  - Outputs during reset: VLP all 1; SEN, DEN, DYNEN, RDY, SSEL, BUSY all 0.
  - Release is synchronous to the first CLK edge with RSTN=1.
  - Reset asserted mid-sequence forces SLEEP immediately, with no quiesce.
- Per-quadrant FSM with independent instances and one timer each. Outputs are a Moore decode of the state register: no combinational path from ON_REQ to outputs.
- SLEEP: VLP=1, SEN=DEN=DYNEN=RDY=0.
  - Edge sampling ON_REQ=1: latch DYN_MODE, load timer=WAKE_CYC-1, go to WAKE.
- WAKE: VLP=0, enables 0.
  - ON_REQ=0 sampled: return to SLEEP next edge (abort allowed; no enable was ever asserted).
  - Timer=0: load SETTLE_CYC-1, go to ENABLE. Otherwise decrement.
- ENABLE: VLP=0; SEN=~mode; DEN=mode; DYNEN=mode.
  - Timer=0: go to ACTIVE, regardless of ON_REQ.
  - Otherwise decrement; ON_REQ is ignored in this state.
- ACTIVE: same enables as ENABLE, plus RDY=1.
  - ON_REQ=0 sampled: load SETTLE_CYC-1, go to QUIESCE.
  - DYN_MODE changes here are ignored.
- QUIESCE: SEN=DEN=0; DYNEN holds the latched mode; VLP=0; RDY=0.
  - Timer=0: go to SLEEP. Otherwise decrement.
  - A new request during QUIESCE does not abort; it is honoured from SLEEP on the following edge.
- Latency:
  - ON_REQ sampled high at edge k in SLEEP gives RDY=1 after edge k+WAKE_CYC+SETTLE_CYC.
  - ON_REQ sampled low at edge j in ACTIVE gives RDY=0 after edge j and VLP=1 after edge j+SETTLE_CYC.
- Invariants, every cycle, per quadrant:
  - SEN and DEN never both 1.
  - Enable=1 implies VLP=0.
  - RDY=1 implies exactly one of SEN/DEN is 1.
- SSEL = OR of the RDY bits. BUSY = OR over quadrants of (state is WAKE, ENABLE or QUIESCE). Both are decoded from registers.
- Quadrants do not interact; simultaneous requests on all quadrants proceed in lockstep.

Test Plan:
- Defaults apply to all scenarios (NUM_QUAD=4, WAKE_CYC=4, SETTLE_CYC=2).
- Reset and static bring-up:
  - Stimulus: release RSTN; ON_REQ=4'b0001 with DYN_MODE=0 sampled at edge 0.
  - Response: VLP=4'b1110 after edge 0; SEN[0]=1 after edge 4; RDY=4'b0001 and SSEL=1 after edge 6.
  - BUSY=1 after edges 0 through 5; DEN=0 throughout.
- Dynamic mode and shutdown:
  - Stimulus: quadrant 2 requested with DYN_MODE[2]=1, then ON_REQ[2]=0 at edge j while ACTIVE.
  - Response: DEN[2]=DYNEN[2]=1 and SEN[2]=0 while ACTIVE; DEN[2]=0 and RDY[2]=0 after edge j; VLP[2]=1 after edge j+2.
- Abort in WAKE:
  - Stimulus: ON_REQ[1] high for 2 cycles, then low.
  - Response: back to SLEEP with VLP[1]=1; SEN[1] and DEN[1] never go to 1.
- Re-request in QUIESCE:
  - Stimulus: drop ON_REQ[3], then raise it again 1 cycle later.
  - Response: QUIESCE completes (VLP[3]=1 for exactly 1 cycle), then a fresh WAKE follows; RDY[3]=1 6 cycles after SLEEP.
- Async reset mid-ENABLE:
  - Stimulus: pulse RSTN low between clock edges while quadrants are in ENABLE.
  - Response: VLP=4'hF and SEN/DEN/RDY/SSEL/BUSY=0 immediately, without waiting for a clock edge.
- Random requests on all quadrants for 10k cycles:
  - Response: a checker confirms every invariant each cycle and the exact latencies above.
